// File: rtl/mem_arbiter.sv
// Two-port memory arbiter for the npc core: IFU (port 0) and LSU (port 1)
// share one memory port, one transaction at a time, with a response timeout.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MASK_W  = 8,
    parameter int RR      = 1,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_rsp_valid,
    input  logic              ifu_rsp_ready,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_rsp_err,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_rsp_valid,
    input  logic              lsu_rsp_ready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rsp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic GNT_IFU = 1'b0;
    localparam logic GNT_LSU = 1'b1;

    // A zero TIMEOUT still needs a one-bit counter to keep the logic legal.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [1:0]        r_state;
    logic              r_gnt;
    logic              r_last;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic [DATA_W-1:0] r_wdata;
    logic [MASK_W-1:0] r_wmask;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    logic w_idle;
    logic w_lsu_win;
    logic w_ifu_acc;
    logic w_lsu_acc;
    logic w_rsp_ready;
    logic w_timeout;
    logic w_resp;

    // Pick the winner while idle; only the winner sees req_ready.
    always_comb begin
        w_idle      = (r_state == S_IDLE) && !rst;
        w_lsu_win   = lsu_req_valid &&
                      ((RR == 0) || !ifu_req_valid || (r_last == GNT_IFU));
        w_lsu_acc   = w_idle && w_lsu_win;
        w_ifu_acc   = w_idle && ifu_req_valid && !w_lsu_win;
        w_rsp_ready = (r_gnt == GNT_LSU) ? lsu_rsp_ready : ifu_rsp_ready;
        w_timeout   = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
        w_resp      = (r_state == S_RESP);
    end

    // Transaction sequencer: grant, issue, wait for memory, hand back result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= GNT_IFU;
            r_last  <= GNT_LSU;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_lsu_acc) begin
                        r_gnt   <= GNT_LSU;
                        r_addr  <= lsu_addr;
                        r_wen   <= lsu_wen;
                        r_wdata <= lsu_wdata;
                        r_wmask <= lsu_wmask;
                        r_state <= S_ISSUE;
                    end else if (w_ifu_acc) begin
                        r_gnt   <= GNT_IFU;
                        r_addr  <= ifu_addr;
                        r_wen   <= 1'b0;
                        r_wdata <= '0;
                        r_wmask <= '0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mem_req_ready) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_rdata <= r_wen ? '0 : mem_rsp_rdata;
                        r_err   <= 1'b0;
                        r_state <= S_RESP;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else if (r_cnt != {CNT_W{1'b1}}) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (w_rsp_ready) begin
                        r_last  <= r_gnt;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Drive the ports from the latched transaction.
    always_comb begin
        ifu_req_ready = w_ifu_acc;
        lsu_req_ready = w_lsu_acc;
        mem_req_valid = (r_state == S_ISSUE);
        mem_addr      = r_addr;
        mem_wen       = r_wen;
        mem_wdata     = r_wdata;
        mem_wmask     = r_wmask;
        ifu_rsp_valid = w_resp && (r_gnt == GNT_IFU);
        lsu_rsp_valid = w_resp && (r_gnt == GNT_LSU);
        ifu_rdata     = ifu_rsp_valid ? r_rdata : '0;
        lsu_rdata     = lsu_rsp_valid ? r_rdata : '0;
        ifu_rsp_err   = ifu_rsp_valid && r_err;
        lsu_rsp_err   = lsu_rsp_valid && r_err;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        ifu_req_valid = 0, ifu_req_ready, ifu_rsp_valid;
    logic        ifu_rsp_ready = 0, ifu_rsp_err;
    logic [31:0] ifu_addr = 0, ifu_rdata;
    logic        lsu_req_valid = 0, lsu_req_ready, lsu_wen = 0;
    logic        lsu_rsp_valid, lsu_rsp_ready = 0, lsu_rsp_err;
    logic [31:0] lsu_addr = 0, lsu_wdata = 0, lsu_rdata;
    logic [7:0]  lsu_wmask = 0, mem_wmask;
    logic        mem_req_valid, mem_req_ready = 0, mem_wen;
    logic        mem_rsp_valid = 0;
    logic [31:0] mem_addr, mem_wdata, mem_rsp_rdata = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MASK_W(8),
                  .RR(1), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr), .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
        .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_rsp_valid(lsu_rsp_valid),
        .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
        .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata)
    );

    // Fixed-priority instance, exercised by a short directed sequence.
    logic        f_rst = 1'b1;
    logic        f_ifu_v = 0, f_ifu_rdy, f_ifu_rv, f_ifu_rr = 0, f_ifu_err;
    logic [31:0] f_ifu_addr = 0, f_ifu_rdata;
    logic        f_lsu_v = 0, f_lsu_rdy, f_lsu_rv, f_lsu_rr = 0, f_lsu_err;
    logic [31:0] f_lsu_addr = 0, f_lsu_rdata;
    logic        f_mrv, f_mrr = 0, f_mwen, f_mrsv = 0;
    logic [31:0] f_maddr, f_mwdata, f_mrdata = 0;
    logic [7:0]  f_mwmask;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MASK_W(8),
                  .RR(0), .TIMEOUT(TO)) dut_fp (
        .clk(clk), .rst(f_rst),
        .ifu_req_valid(f_ifu_v), .ifu_req_ready(f_ifu_rdy),
        .ifu_addr(f_ifu_addr), .ifu_rsp_valid(f_ifu_rv),
        .ifu_rsp_ready(f_ifu_rr), .ifu_rdata(f_ifu_rdata),
        .ifu_rsp_err(f_ifu_err),
        .lsu_req_valid(f_lsu_v), .lsu_req_ready(f_lsu_rdy),
        .lsu_addr(f_lsu_addr), .lsu_wen(1'b0), .lsu_wdata(32'h0),
        .lsu_wmask(8'h0), .lsu_rsp_valid(f_lsu_rv),
        .lsu_rsp_ready(f_lsu_rr), .lsu_rdata(f_lsu_rdata),
        .lsu_rsp_err(f_lsu_err),
        .mem_req_valid(f_mrv), .mem_req_ready(f_mrr),
        .mem_addr(f_maddr), .mem_wen(f_mwen), .mem_wdata(f_mwdata),
        .mem_wmask(f_mwmask), .mem_rsp_valid(f_mrsv),
        .mem_rsp_rdata(f_mrdata)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Transaction-level reference: 0 idle, 1 issuing, 2 awaiting
    // memory, 3 returning result to the requester.
    int          m_ph = 0;
    int          m_wait = 0;
    logic        m_port = 0, m_last = 1, m_wen = 0, m_err = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
    logic [7:0]  m_wmask = 0;
    logic        acc_i = 0, acc_l = 0;
    logic        e_ir, e_lr;

    always @(negedge clk) begin
        if (rst) begin
            m_ph = 0; m_last = 1; m_wait = 0;
            acc_i = 0; acc_l = 0;
        end else begin
            e_lr = (m_ph == 0) && lsu_req_valid &&
                   (!ifu_req_valid || m_last == 1'b0);
            e_ir = (m_ph == 0) && ifu_req_valid && !e_lr;
            chk("m_ifu_req_ready", ifu_req_ready, e_ir);
            chk("m_lsu_req_ready", lsu_req_ready, e_lr);
            chk("m_mem_req_valid", mem_req_valid, m_ph == 1);
            if (m_ph == 1) begin
                chk("m_mem_addr", mem_addr, m_addr);
                chk("m_mem_wen", mem_wen, m_wen);
                chk("m_mem_wdata", mem_wdata, m_wdata);
                chk("m_mem_wmask", mem_wmask, m_wmask);
            end
            chk("m_ifu_rsp_valid", ifu_rsp_valid, m_ph == 3 && !m_port);
            chk("m_lsu_rsp_valid", lsu_rsp_valid, m_ph == 3 && m_port);
            if (m_ph == 3) begin
                chk("m_rdata", m_port ? lsu_rdata : ifu_rdata, m_rdata);
                chk("m_err", m_port ? lsu_rsp_err : ifu_rsp_err, m_err);
            end
            acc_i = ifu_req_valid && ifu_req_ready;
            acc_l = lsu_req_valid && lsu_req_ready;
            case (m_ph)
                0: if (e_lr) begin
                    m_port = 1; m_addr = lsu_addr; m_wen = lsu_wen;
                    m_wdata = lsu_wdata; m_wmask = lsu_wmask; m_ph = 1;
                end else if (e_ir) begin
                    m_port = 0; m_addr = ifu_addr; m_wen = 0;
                    m_wdata = 0; m_wmask = 0; m_ph = 1;
                end
                1: if (mem_req_ready) begin
                    m_ph = 2; m_wait = 0;
                end
                2: if (mem_rsp_valid) begin
                    m_rdata = m_wen ? 32'h0 : mem_rsp_rdata;
                    m_err = 0; m_ph = 3;
                end else if (m_wait == TO - 1) begin
                    m_rdata = 0; m_err = 1; m_ph = 3;
                end else begin
                    m_wait++;
                end
                3: if (m_port ? lsu_rsp_ready : ifu_rsp_ready) begin
                    m_ph = 0; m_last = m_port;
                end
                default: m_ph = 0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ifu_rdy"}, ifu_req_ready, 0);
        chk({tag, "_lsu_rdy"}, lsu_req_ready, 0);
        chk({tag, "_mem_rv"}, mem_req_valid, 0);
        chk({tag, "_ifu_rv"}, ifu_rsp_valid, 0);
        chk({tag, "_lsu_rv"}, lsu_rsp_valid, 0);
        chk({tag, "_ifu_rd"}, ifu_rdata, 0);
        chk({tag, "_lsu_rd"}, lsu_rdata, 0);
        chk({tag, "_errs"}, {ifu_rsp_err, lsu_rsp_err}, 0);
        chk({tag, "_maddr"}, mem_addr, 0);
    endtask

    initial begin
        // Reset state.
        step(); step();
        @(negedge clk);
        chk_quiet("reset");

        // Tie after reset: IFU first; then response hold; then LSU.
        step();
        rst = 0;
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        lsu_req_valid = 1; lsu_addr = 32'h8000_0100; lsu_wen = 0;
        mem_req_ready = 1; mem_rsp_valid = 1;
        mem_rsp_rdata = 32'h0010_0073;
        @(negedge clk);
        chk("tie_ifu_rdy", ifu_req_ready, 1);
        chk("tie_lsu_rdy", lsu_req_ready, 0);
        step();
        ifu_req_valid = 0;
        @(negedge clk);
        chk("issue_mem_rv", mem_req_valid, 1);
        chk("issue_addr", mem_addr, 32'h8000_0000);
        step();
        @(negedge clk);
        chk("lat_not_yet", ifu_rsp_valid, 0);
        step();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_rv", ifu_rsp_valid, 1);
            chk("hold_rd", ifu_rdata, 32'h0010_0073);
            chk("hold_err", ifu_rsp_err, 0);
            chk("hold_nogrant", {ifu_req_ready, lsu_req_ready}, 0);
            step();
        end
        ifu_rsp_ready = 1;
        step();
        ifu_rsp_ready = 0;
        @(negedge clk);
        chk("rr_lsu_rdy", lsu_req_ready, 1);
        chk("rr_ifu_rdy", ifu_req_ready, 0);
        step();
        lsu_req_valid = 0;
        step(); step();
        @(negedge clk);
        chk("lsu_rv", lsu_rsp_valid, 1);
        chk("lsu_rd", lsu_rdata, 32'h0010_0073);
        chk("lsu_ifu_rv", ifu_rsp_valid, 0);
        lsu_rsp_ready = 1;
        step();
        lsu_rsp_ready = 0;
        @(negedge clk);
        chk("rr_back_ifu", ifu_req_ready, 1);
        step();
        ifu_req_valid = 0; ifu_rsp_ready = 1;
        step(); step(); step();
        ifu_rsp_ready = 0;

        // Write with memory stalling five cycles.
        lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_1000;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F;
        mem_req_ready = 0; mem_rsp_valid = 0;
        step();
        lsu_req_valid = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rv", mem_req_valid, 1);
            chk("stall_addr", mem_addr, 32'h8000_1000);
            chk("stall_wen", mem_wen, 1);
            chk("stall_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("stall_wmask", mem_wmask, 8'h0F);
            step();
        end
        mem_req_ready = 1;
        step();
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h1234_5678;
        step();
        mem_rsp_valid = 0;
        @(negedge clk);
        chk("wr_rv", lsu_rsp_valid, 1);
        chk("wr_rd", lsu_rdata, 0);
        chk("wr_err", lsu_rsp_err, 0);
        lsu_rsp_ready = 1;
        step();
        lsu_rsp_ready = 0; lsu_wen = 0;

        // Timeout, then late response ignored.
        ifu_req_valid = 1; ifu_addr = 32'h8000_0008; mem_req_ready = 1;
        step();
        ifu_req_valid = 0;
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_wait", ifu_rsp_valid, 0);
            step();
        end
        @(negedge clk);
        chk("to_rv", ifu_rsp_valid, 1);
        chk("to_err", ifu_rsp_err, 1);
        chk("to_rd", ifu_rdata, 0);
        mem_rsp_valid = 1; mem_rsp_rdata = 32'hAAAA_5555;
        step();
        @(negedge clk);
        chk("late_rd", ifu_rdata, 0);
        chk("late_err", ifu_rsp_err, 1);
        ifu_rsp_ready = 1;
        step();
        ifu_rsp_ready = 0;
        ifu_req_valid = 1; ifu_addr = 32'h8000_000C; mem_req_ready = 0;
        step();
        ifu_req_valid = 0;
        @(negedge clk);
        chk("late_issue", mem_req_valid, 1);
        mem_req_ready = 1; mem_rsp_valid = 0;
        step();
        mem_rsp_valid = 1; mem_rsp_rdata = 32'h0000_0013;
        step();
        mem_rsp_valid = 0;
        @(negedge clk);
        chk("after_to_rd", ifu_rdata, 32'h0000_0013);
        chk("after_to_err", ifu_rsp_err, 0);
        ifu_rsp_ready = 1;
        step();
        ifu_rsp_ready = 0;

        // Reset during WAIT_RSP.
        ifu_req_valid = 1; ifu_addr = 32'h8000_0010;
        step();
        ifu_req_valid = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        chk_quiet("midrst");
        ifu_req_valid = 1; ifu_addr = 32'h8000_0020;
        mem_rsp_valid = 1; mem_rsp_rdata = 32'h0000_0093; ifu_rsp_ready = 1;
        #1;
        chk("midrst_acc", ifu_req_ready, 1);
        step();
        ifu_req_valid = 0;
        step(); step();
        @(negedge clk);
        chk("midrst_rd", ifu_rdata, 32'h0000_0093);
        step();

        // Randomized traffic; the model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 249) == 0);
            if (!ifu_req_valid || acc_i) begin
                ifu_req_valid = $urandom_range(0, 1);
                ifu_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!lsu_req_valid || acc_l) begin
                lsu_req_valid = $urandom_range(0, 1);
                lsu_addr = $urandom;
                lsu_wen = $urandom_range(0, 1);
                lsu_wdata = $urandom;
                lsu_wmask = 8'($urandom);
            end
            mem_req_ready = $urandom_range(0, 1);
            mem_rsp_valid = ($urandom_range(0, 9) < 3);
            mem_rsp_rdata = $urandom;
            ifu_rsp_ready = $urandom_range(0, 1);
            lsu_rsp_ready = $urandom_range(0, 1);
            step();
        end
        rst = 0;

        // Fixed priority: LSU always wins a tie.
        step();
        f_rst = 0;
        f_ifu_v = 1; f_ifu_addr = 32'h8000_3000;
        f_lsu_v = 1; f_lsu_addr = 32'h8000_2000;
        @(negedge clk);
        chk("fp_lsu_rdy", f_lsu_rdy, 1);
        chk("fp_ifu_rdy", f_ifu_rdy, 0);
        step();
        f_lsu_v = 0;
        @(negedge clk);
        chk("fp_mem_rv", f_mrv, 1);
        chk("fp_mem_addr", f_maddr, 32'h8000_2000);
        f_mrr = 1; f_mrsv = 1; f_mrdata = 32'h0000_0055;
        step(); step();
        @(negedge clk);
        chk("fp_lsu_rd", f_lsu_rdata, 32'h0000_0055);
        chk("fp_lsu_rv", f_lsu_rv, 1);
        f_lsu_rr = 1;
        step();
        f_lsu_rr = 0; f_lsu_v = 1;
        @(negedge clk);
        chk("fp_again_lsu", f_lsu_rdy, 1);
        chk("fp_again_ifu", f_ifu_rdy, 0);
        f_lsu_v = 0;
        #1;
        chk("fp_ifu_alone", f_ifu_rdy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
